// File: rtl/spi_slave_regfile.sv
// ----------------------------------------------------------------------------
// spi_slave_regfile : SPI responder exposing NREG 8-bit registers (SCK domain)
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave_regfile #(
  parameter int NREG = 16
) (
  input  logic              SCK,
  input  logic              reset,
  input  logic              SSB,
  input  logic              MOSI,
  output logic              MISO,
  output logic [NREG*8-1:0] reg_out,
  output logic              wr_strobe,
  output logic [6:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_end
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic [6:0] addr;
  logic       blocked;
  logic       active;

  logic [7:0] byte_in;
  logic       byte_done;
  logic       addr_ok;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  assign byte_in   = {shift_in, MOSI};
  assign byte_done = (bit_cnt == 3'd7);
  assign addr_ok   = ({1'b0, addr} < 8'(NREG));
  assign MISO      = (state == S_RDATA) ? shift_out[7] : 1'b0;

  // Read port: the command byte supplies the first address, later loads use addr+1
  always_comb begin
    rd_addr = (state == S_CMD) ? byte_in[6:0] : addr + 7'd1;
    rd_data = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (rd_addr == 7'(k)) rd_data = reg_out[8*k +: 8];
    end
  end

  always_ff @(posedge SCK) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'd0;
      addr      <= 7'd0;
      blocked   <= 1'b1;
      active    <= 1'b0;
      reg_out   <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 8'd0;
      frame_end <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_end <= 1'b0;
      if (SSB) begin
        state     <= S_IDLE;
        bit_cnt   <= 3'd0;
        shift_in  <= 7'd0;
        shift_out <= 8'd0;
        blocked   <= 1'b0;
        frame_end <= active;
        active    <= 1'b0;
      end else if (!blocked) begin
        // blocked holds off the tail of a frame interrupted by reset
        active   <= 1'b1;
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= byte_in[6:0];
        case (state)
          S_IDLE: state <= S_CMD;
          S_CMD: begin
            if (byte_done) begin
              addr <= byte_in[6:0];
              if (byte_in[7]) begin
                state     <= S_RDATA;
                shift_out <= rd_data;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (byte_done) begin
              addr <= addr + 7'd1;
              if (addr_ok) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= byte_in;
              end
              for (int k = 0; k < NREG; k++) begin
                if (addr == 7'(k)) reg_out[8*k +: 8] <= byte_in;
              end
            end
          end
          default: begin
            if (byte_done) begin
              addr      <= addr + 7'd1;
              shift_out <= rd_data;
            end else begin
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
